// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   MEM-stage load/store unit. Accepts one load or store from the EX/MEM slot,
//   runs it over a req/ack data-memory port and returns sign/zero-extended
//   load data for writeback. The pipeline is held (stall_out) from the issuing
//   cycle until the memory acknowledges, or until the access times out.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   valid_in        EX/MEM slot holds a live instruction
//   opcode_in       0000011 LOAD, 0100011 STORE, anything else ignored
//   funct3_in       RV32I access size/sign
//   addr_in         effective byte address
//   wdata_in        store data (rs2)
//   rd_addr_in      load destination register
//   stall_out       hold upstream stages (combinational)
//   mem_req_out     registered memory request, held until ack/timeout
//   mem_we_out      1 = write
//   mem_addr_out    word-aligned address
//   mem_wstrb_out   byte enables for stores, 0 for loads
//   mem_wdata_out   lane-replicated store data
//   mem_ack_in      one-cycle completion, mem_rdata_in valid with it
//   mem_rdata_in    read word
//   wb_valid_out    one-cycle writeback pulse
//   wb_rd_out       writeback register
//   wb_data_out     extended load data
//   exc_out         one-cycle exception pulse
//   exc_code_out    01 misaligned/illegal, 10 timeout, 00 none
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_addr_in,
    output logic        stall_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [3:0]  mem_wstrb_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        wb_valid_out,
    output logic [4:0]  wb_rd_out,
    output logic [31:0] wb_data_out,
    output logic        exc_out,
    output logic [1:0]  exc_code_out
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam int unsigned     CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [4:0]    rd_q, rd_d;
    logic [2:0]    f3_q, f3_d;
    logic          we_q, we_d;
    logic [3:0]    strb_q, strb_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_q, req_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          exc_q, exc_d;
    logic [1:0]    exc_code_q, exc_code_d;

    logic        is_load, is_store, start, legal;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    // Select the addressed byte/half of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'b0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    assign is_load  = (opcode_in == OP_LOAD);
    assign is_store = (opcode_in == OP_STORE);
    assign start    = (state_q == S_IDLE) && valid_in && (is_load || is_store);

    // Issuing cycle is held combinationally; RESP releases the pipeline so
    // it advances in the same cycle writeback fires.
    assign stall_out = start || (state_q == S_ACCESS);

    always_comb begin
        legal = 1'b0;
        if (is_load) begin
            case (funct3_in)
                3'd0, 3'd4: legal = 1'b1;
                3'd1, 3'd5: legal = ~addr_in[0];
                3'd2:       legal = (addr_in[1:0] == 2'b00);
                default:    legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3_in)
                3'd0:    legal = 1'b1;
                3'd1:    legal = ~addr_in[0];
                3'd2:    legal = (addr_in[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end
    end

    // Store lane alignment: data is replicated across lanes, strobes select.
    always_comb begin
        st_strb = 4'b0000;
        st_data = 32'h0;
        if (is_store) begin
            case (funct3_in[1:0])
                2'd0: begin
                    st_strb = 4'b0001 << addr_in[1:0];
                    st_data = {4{wdata_in[7:0]}};
                end
                2'd1: begin
                    st_strb = 4'b0011 << {addr_in[1], 1'b0};
                    st_data = {2{wdata_in[15:0]}};
                end
                default: begin
                    st_strb = 4'b1111;
                    st_data = wdata_in;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        we_d       = we_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        req_d      = req_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        exc_d      = 1'b0;
        exc_code_d = EXC_NONE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = S_ACCESS;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        addr_d  = addr_in;
                        rd_d    = rd_addr_in;
                        f3_d    = funct3_in;
                        we_d    = is_store;
                        strb_d  = st_strb;
                        wdata_d = st_data;
                    end else begin
                        exc_d      = 1'b1;
                        exc_code_d = EXC_ILLEGAL;
                    end
                end
            end
            S_ACCESS: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (mem_ack_in) begin
                    req_d   = 1'b0;
                    state_d = S_RESP;
                    if (!we_q) begin
                        wb_valid_d = (rd_q != 5'd0);
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_extract(f3_q, addr_q[1:0], mem_rdata_in);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d      = 1'b0;
                    state_d    = S_IDLE;
                    exc_d      = 1'b1;
                    exc_code_d = EXC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'h0;
            rd_q       <= 5'd0;
            f3_q       <= 3'd0;
            we_q       <= 1'b0;
            strb_q     <= 4'b0000;
            wdata_q    <= 32'h0;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
            exc_q      <= 1'b0;
            exc_code_q <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            we_q       <= we_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    assign mem_req_out   = req_q;
    assign mem_we_out    = we_q;
    assign mem_addr_out  = {addr_q[31:2], 2'b00};
    assign mem_wstrb_out = strb_q;
    assign mem_wdata_out = wdata_q;
    assign wb_valid_out  = wb_valid_q;
    assign wb_rd_out     = wb_rd_q;
    assign wb_data_out   = wb_data_q;
    assign exc_out       = exc_q;
    assign exc_code_out  = exc_code_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Directed bench for lsu_mem_ctrl. Expected writebacks and exceptions are
//   queued when a request is issued and popped when the DUT pulses them;
//   memory-port outputs are checked every cycle the request is raised.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [6:0]  opcode_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [4:0]  rd_addr_in;
    logic        stall_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_wstrb_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        wb_valid_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;
    logic        exc_out;
    logic [1:0]  exc_code_out;

    lsu_mem_ctrl #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .opcode_in     (opcode_in),
        .funct3_in     (funct3_in),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
        .rd_addr_in    (rd_addr_in),
        .stall_out     (stall_out),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wstrb_out (mem_wstrb_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_ack_in    (mem_ack_in),
        .mem_rdata_in  (mem_rdata_in),
        .wb_valid_out  (wb_valid_out),
        .wb_rd_out     (wb_rd_out),
        .wb_data_out   (wb_data_out),
        .exc_out       (exc_out),
        .exc_code_out  (exc_code_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t        wb_q[$];
    logic [1:0] exc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;
    int req_cnt;

    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Per-cycle observation, taken at the falling edge.
    task automatic monitor();
        wb_t        e;
        logic [1:0] c;
        if (stall_out) stall_cnt++;
        if (mem_req_out) begin
            req_cnt++;
            check("mem_addr", mem_addr_out, exp_addr);
            check("mem_we", 32'(mem_we_out), 32'(exp_we));
            check("mem_wstrb", 32'(mem_wstrb_out), 32'(exp_strb));
            if (exp_we) check("mem_wdata", mem_wdata_out, exp_wdata);
        end
        if (wb_valid_out) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid_out), 32'd0);
            end else begin
                e = wb_q.pop_front();
                check("wb_rd", 32'(wb_rd_out), 32'(e.rd));
                check("wb_data", wb_data_out, e.data);
            end
        end
        if (exc_out) begin
            if (exc_q.size() == 0) begin
                check("exc_unexpected", 32'(exc_out), 32'd0);
            end else begin
                c = exc_q.pop_front();
                check("exc_code", 32'(exc_code_out), 32'(c));
            end
        end else begin
            check("exc_code_idle", 32'(exc_code_out), 32'd0);
        end
    endtask

    // One clock: inputs already set; observe at negedge, return just past posedge.
    task automatic clk_step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, answer it with ack in ACCESS cycle ack_lat (0 = never),
    // then let the bench run long enough to cover a full timeout.
    task automatic access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int ack_lat,
                          input logic [31:0] rdata, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic e_wb,
                          input logic [31:0] e_data, input logic [1:0] e_exc,
                          input int e_stall, input int e_req);
        stall_cnt = 0;
        req_cnt   = 0;
        exp_addr  = {addr[31:2], 2'b00};
        exp_we    = (op == OP_STORE);
        exp_strb  = e_strb;
        exp_wdata = e_wdata;
        if (e_wb) wb_q.push_back('{rd: rd, data: e_data});
        if (e_exc != 2'b00) exc_q.push_back(e_exc);

        valid_in   = 1'b1;
        opcode_in  = op;
        funct3_in  = f3;
        addr_in    = addr;
        wdata_in   = wd;
        rd_addr_in = rd;
        clk_step();
        valid_in   = 1'b0;
        opcode_in  = 7'd0;
        addr_in    = 32'h0;
        wdata_in   = 32'h0;

        for (int c = 1; c <= 24; c++) begin
            if (c == ack_lat) begin
                mem_ack_in   = 1'b1;
                mem_rdata_in = rdata;
            end else begin
                mem_ack_in   = 1'b0;
                mem_rdata_in = 32'hA5A5_5A5A;
            end
            clk_step();
        end
        mem_ack_in = 1'b0;

        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(e_stall));
        check({tag, "_req_cycles"}, 32'(req_cnt), 32'(e_req));
        check({tag, "_wb_pending"}, 32'(wb_q.size()), 32'd0);
        check({tag, "_exc_pending"}, 32'(exc_q.size()), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        valid_in     = 1'b0;
        opcode_in    = 7'd0;
        funct3_in    = 3'd0;
        addr_in      = 32'h0;
        wdata_in     = 32'h0;
        rd_addr_in   = 5'd0;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        stall_cnt    = 0;
        req_cnt      = 0;
        exp_addr     = 32'h0;
        exp_we       = 1'b0;
        exp_strb     = 4'h0;
        exp_wdata    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_addr", mem_addr_out, 32'h0);
        check("rst_wstrb", 32'(mem_wstrb_out), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_out), 32'd0);
        check("rst_exc", 32'(exc_out), 32'd0);
        rst = 1'b0;

        //      tag       op        f3    addr          wdata          rd  ack rdata         strb     wdata         wb    data          exc    stall req
        access("lw",    OP_LOAD,  3'd2, 32'h0000_0100, 32'h0,         5'd1, 3, 32'hDEAD_BEEF, 4'b0000, 32'h0,        1'b1, 32'hDEAD_BEEF, 2'b00, 4,  3);
        access("lb",    OP_LOAD,  3'd0, 32'h0000_0103, 32'h0,         5'd2, 1, 32'h80FF_0000, 4'b0000, 32'h0,        1'b1, 32'hFFFF_FF80, 2'b00, 2,  1);
        access("lbu",   OP_LOAD,  3'd4, 32'h0000_0103, 32'h0,         5'd3, 2, 32'h80FF_0000, 4'b0000, 32'h0,        1'b1, 32'h0000_0080, 2'b00, 3,  2);
        access("lb_pos",OP_LOAD,  3'd0, 32'h0000_0101, 32'h0,         5'd4, 1, 32'h0000_7F00, 4'b0000, 32'h0,        1'b1, 32'h0000_007F, 2'b00, 2,  1);
        access("lh",    OP_LOAD,  3'd1, 32'h0000_0102, 32'h0,         5'd5, 1, 32'h80FF_0000, 4'b0000, 32'h0,        1'b1, 32'hFFFF_80FF, 2'b00, 2,  1);
        access("lhu",   OP_LOAD,  3'd5, 32'h0000_0100, 32'h0,         5'd6, 2, 32'h1234_8001, 4'b0000, 32'h0,        1'b1, 32'h0000_8001, 2'b00, 3,  2);
        access("sh",    OP_STORE, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd7, 2, 32'h0,         4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0,        2'b00, 3,  2);
        access("sb",    OP_STORE, 3'd0, 32'h0000_0301, 32'h0000_00A7, 5'd8, 1, 32'h0,         4'b0010, 32'hA7A7_A7A7, 1'b0, 32'h0,        2'b00, 2,  1);
        access("sw",    OP_STORE, 3'd2, 32'h0000_0404, 32'hCAFE_F00D, 5'd9, 4, 32'h0,         4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        2'b00, 5,  4);
        access("lw_x0", OP_LOAD,  3'd2, 32'h0000_0010, 32'h0,         5'd0, 1, 32'h1111_2222, 4'b0000, 32'h0,        1'b0, 32'h0,        2'b00, 2,  1);
        access("lw_mis",OP_LOAD,  3'd2, 32'h0000_0101, 32'h0,         5'd1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        2'b01, 1,  0);
        access("sh_mis",OP_STORE, 3'd1, 32'h0000_0203, 32'h5555_5555, 5'd1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        2'b01, 1,  0);
        access("ld_f3", OP_LOAD,  3'd3, 32'h0000_0000, 32'h0,         5'd1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        2'b01, 1,  0);
        access("st_f3", OP_STORE, 3'd3, 32'h0000_0000, 32'h0,         5'd1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        2'b01, 1,  0);
        access("alu",   OP_ALU,   3'd2, 32'h0000_0100, 32'h0,         5'd1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        2'b00, 0,  0);
        access("tmo",   OP_LOAD,  3'd2, 32'h0000_0500, 32'h0,         5'd1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        2'b10, 17, 16);
        access("ack16", OP_LOAD,  3'd2, 32'h0000_0504, 32'h0,         5'd2, 16, 32'h7777_0001,4'b0000, 32'h0,        1'b1, 32'h7777_0001, 2'b00, 17, 16);

        // Reset on the second ACCESS cycle, memory acks one cycle late.
        stall_cnt  = 0;
        req_cnt    = 0;
        exp_addr   = 32'h0000_0300;
        exp_we     = 1'b0;
        exp_strb   = 4'b0000;
        valid_in   = 1'b1;
        opcode_in  = OP_LOAD;
        funct3_in  = 3'd2;
        addr_in    = 32'h0000_0300;
        rd_addr_in = 5'd9;
        clk_step();
        valid_in   = 1'b0;
        opcode_in  = 7'd0;
        clk_step();
        rst = 1'b1;
        clk_step();
        rst          = 1'b0;
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h1357_9BDF;
        check("mrst_req", 32'(mem_req_out), 32'd0);
        check("mrst_we", 32'(mem_we_out), 32'd0);
        check("mrst_addr", mem_addr_out, 32'h0);
        check("mrst_wstrb", 32'(mem_wstrb_out), 32'd0);
        check("mrst_wdata", mem_wdata_out, 32'h0);
        check("mrst_stall", 32'(stall_out), 32'd0);
        check("mrst_wb_rd", 32'(wb_rd_out), 32'd0);
        check("mrst_wb_data", wb_data_out, 32'h0);
        check("mrst_exc", 32'(exc_out), 32'd0);
        clk_step();
        mem_ack_in = 1'b0;
        repeat (4) clk_step();
        check("mrst_req_cycles", 32'(req_cnt), 32'd2);
        check("mrst_stall_cycles", 32'(stall_cnt), 32'd3);
        check("mrst_wb_pending", 32'(wb_q.size()), 32'd0);

        // The unit must accept a fresh access after the mid-flight reset.
        access("post_rst", OP_LOAD, 3'd4, 32'h0000_0002, 32'h0, 5'd10, 1, 32'h00AB_0000, 4'b0000, 32'h0, 1'b1, 32'h0000_00AB, 2'b00, 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
